// File: rtl/spi_pwm_pkg.sv
// Shared command codes and receiver state encoding for the SPI duty-cycle
// receiver.
package spi_pwm_pkg;

    localparam logic [7:0] CMD_WR_DUTY = 8'h01;
    localparam logic [7:0] CMD_WR_EN   = 8'h02;
    localparam logic [7:0] CMD_RD      = 8'h03;

    typedef enum logic [2:0] {
        ST_WAIT_HIGH,
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with one-clk
// rise and fall strobes taken from the synchronized level.
module spi_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_duty_rx.sv
// SPI mode-0 slave that receives {command, data} frames and drives the PWM
// duty/enable registers, with duty readback on MISO during the data byte.
module spi_duty_rx
    import spi_pwm_pkg::*;
#(
    parameter logic [7:0]  DEFAULT_DUTY = 8'd0,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic [7:0] duty,
    output logic       pwm_en,
    output logic       duty_upd,
    output logic       frame_err
);

    localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SYNC_STAGES + 1);

    logic sclk_q_unused, sclk_rise, sclk_fall;
    logic mosi_q, mosi_rise_unused, mosi_fall_unused;
    logic cs_q, cs_rise, cs_fall;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(spi_sclk),
        .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(spi_mosi),
        .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(spi_cs_n),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    state_t              state;
    logic [SETTLE_W-1:0] settle;
    logic [2:0]          bit_cnt;
    logic [7:0]          shreg;
    logic [7:0]          cmd;
    logic [7:0]          miso_sr;
    logic [7:0]          shift_in;

    assign shift_in = {shreg[6:0], mosi_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_WAIT_HIGH;
            settle    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            cmd       <= '0;
            miso_sr   <= '0;
            spi_miso  <= 1'b0;
            duty      <= DEFAULT_DUTY;
            pwm_en    <= 1'b0;
            duty_upd  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            duty_upd  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                // The cs_n chain resets high, so its level is only trusted
                // once real pin samples have flushed the whole chain.
                ST_WAIT_HIGH: begin
                    if (settle != SETTLE_LAST)
                        settle <= settle + 1'b1;
                    else if (cs_q)
                        state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        shreg   <= '0;
                        state   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (sclk_rise) begin
                        shreg   <= shift_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            cmd      <= shift_in;
                            miso_sr  <= duty;
                            spi_miso <= duty[7];
                            state    <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        spi_miso  <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (sclk_rise) begin
                        shreg   <= shift_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            spi_miso <= 1'b0;
                            state    <= ST_DONE;
                            case (cmd)
                                CMD_WR_DUTY: begin
                                    duty     <= shift_in;
                                    duty_upd <= 1'b1;
                                end
                                CMD_WR_EN: pwm_en <= shift_in[0];
                                CMD_RD:    ;
                                default:   frame_err <= 1'b1;
                            endcase
                        end
                    end else if (sclk_fall && bit_cnt != 3'd0) begin
                        // The fall that closes the command byte must not
                        // shift, or the master would never sample bit 7.
                        miso_sr  <= {miso_sr[6:0], 1'b0};
                        spi_miso <= miso_sr[6];
                    end
                end
                ST_DONE: begin
                    if (cs_rise)
                        state <= ST_IDLE;
                end
                default: state <= ST_WAIT_HIGH;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_duty_rx.sv
// Directed bench for spi_duty_rx: stimulus pushes expected update/error
// events into a queue that a clocked monitor pops as the DUT pulses.
module tb_spi_duty_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       spi_miso;
    logic [7:0] duty;
    logic       pwm_en;
    logic       duty_upd;
    logic       frame_err;

    spi_duty_rx #(.DEFAULT_DUTY(8'd0), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .spi_miso(spi_miso), .duty(duty), .pwm_en(pwm_en),
        .duty_upd(duty_upd), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] val;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [7:0]  rx;
    logic [7:0]  junk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic expect_upd(input logic [7:0] v);
        ev_t e;
        e.is_err = 1'b0;
        e.val    = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        ev_t e;
        e.is_err = 1'b1;
        e.val    = 8'h00;
        exp_q.push_back(e);
    endtask

    // Mode 0: MOSI changes while SCLK is low; MISO is sampled on the rise.
    task automatic send_bits(input logic [7:0] tx, input int unsigned n, output logic [7:0] r);
        r = '0;
        for (int unsigned i = 0; i < n; i++) begin
            spi_mosi = tx[7-i];
            #80 spi_sclk = 1'b1;
            r = {r[6:0], spi_miso};
            #80 spi_sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] d,
                         input int unsigned extra, output logic [7:0] r);
        logic [7:0] dummy;
        spi_cs_n = 1'b0;
        #80;
        send_bits(c, 8, dummy);
        send_bits(d, 8, r);
        if (extra != 0)
            send_bits(8'hFF, extra, dummy);
        #80 spi_cs_n = 1'b1;
        #240;
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (duty_upd) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL upd_unexpected: got duty_upd with duty %02h, required no pulse", duty);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.is_err || duty !== e.val) begin
                        n_bad++;
                        $display("FAIL upd_event: got duty_upd duty=%02h, required err=%0d val=%02h",
                                 duty, e.is_err, e.val);
                    end
                end
            end
            if (frame_err) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL err_unexpected: got frame_err, required no pulse");
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (!e.is_err) begin
                        n_bad++;
                        $display("FAIL err_event: got frame_err, required duty_upd with %02h", e.val);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        #23;
        check8("rst_duty", duty, 8'h00);
        check8("rst_pwm_en", {7'd0, pwm_en}, 8'h00);
        check8("rst_miso", {7'd0, spi_miso}, 8'h00);
        check8("rst_duty_upd", {7'd0, duty_upd}, 8'h00);
        check8("rst_frame_err", {7'd0, frame_err}, 8'h00);
        #10 rst = 1'b0;
        #100;

        expect_upd(8'hA5);
        frame(8'h01, 8'hA5, 0, rx);
        check8("wr_a5_readback", rx, 8'h00);
        check8("wr_a5_duty", duty, 8'hA5);
        check8("idle_miso", {7'd0, spi_miso}, 8'h00);

        frame(8'h02, 8'h01, 0, rx);
        check8("en1_pwm_en", {7'd0, pwm_en}, 8'h01);
        check8("en1_duty", duty, 8'hA5);

        frame(8'h03, 8'h00, 0, rx);
        check8("rd_readback", rx, 8'hA5);
        check8("rd_duty", duty, 8'hA5);
        check8("rd_pwm_en", {7'd0, pwm_en}, 8'h01);

        expect_err();
        frame(8'h7E, 8'h55, 0, rx);
        check8("badcmd_duty", duty, 8'hA5);
        check8("badcmd_pwm_en", {7'd0, pwm_en}, 8'h01);

        // Abort: full command byte, five data bits, then CS rises.
        expect_err();
        spi_cs_n = 1'b0;
        #80;
        send_bits(8'h01, 8, junk);
        send_bits(8'hF8, 5, junk);
        #80 spi_cs_n = 1'b1;
        #240;
        check8("abort_duty", duty, 8'hA5);

        expect_upd(8'h10);
        frame(8'h01, 8'h10, 0, rx);
        check8("wr_10_readback", rx, 8'hA5);
        check8("wr_10_duty", duty, 8'h10);

        frame(8'h02, 8'h00, 0, rx);
        check8("en0_pwm_en", {7'd0, pwm_en}, 8'h00);
        check8("en0_readback", rx, 8'h10);

        expect_upd(8'h10);
        frame(8'h01, 8'h10, 0, rx);
        check8("same_val_duty", duty, 8'h10);

        // Reset in the middle of a frame with CS held low throughout.
        spi_cs_n = 1'b0;
        #80;
        send_bits(8'h01, 8, junk);
        send_bits(8'h77, 3, junk);
        #20 rst = 1'b1;
        #40 rst = 1'b0;
        #20;
        check8("midrst_duty", duty, 8'h00);
        send_bits(8'hB8, 5, junk);
        send_bits(8'h01, 8, junk);
        #80 spi_cs_n = 1'b1;
        #240;
        check8("midrst_after_duty", duty, 8'h00);
        check8("midrst_after_pwm_en", {7'd0, pwm_en}, 8'h00);

        expect_upd(8'hFF);
        frame(8'h01, 8'hFF, 0, rx);
        check8("wr_ff_duty", duty, 8'hFF);

        expect_upd(8'h33);
        frame(8'h01, 8'h33, 8, rx);
        check8("extra_clk_duty", duty, 8'h33);
        check8("extra_clk_readback", rx, 8'hFF);

        #200;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: got %0d unmatched expectations, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
